// File: rtl/oam_dma.sv
// Sprite DMA initiator: on a CPU write to DMA_REG it stalls the CPU and copies one
// 256-byte page into the PPU OAM data port; otherwise CPU bus traffic passes straight through.
module oam_dma #(
  parameter logic [15:0] DMA_REG = 16'h4014,
  parameter logic [15:0] OAM_REG = 16'h2004
) (
  input  logic        CLKCPU,
  input  logic        RESET,
  input  logic [15:0] ea_cpu,
  input  logic [7:0]  din_cpu,
  input  logic        wreq_cpu,
  input  logic        rd_cpu,
  input  logic [7:0]  bdata,
  output logic [15:0] ea,
  output logic [7:0]  din,
  output logic        WREQ,
  output logic        RD,
  output logic        RDY,
  output logic        BUSY
);

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

  state_t      state;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [7:0]  latch;
  logic        cyc;

  always_ff @(posedge CLKCPU) begin
    if (RESET) begin
      state <= IDLE;
      page  <= 8'd0;
      idx   <= 8'd0;
      latch <= 8'd0;
      cyc   <= 1'b0;
    end else begin
      cyc <= ~cyc;
      case (state)
        IDLE: begin
          if (wreq_cpu && (ea_cpu == DMA_REG)) begin
            page  <= din_cpu;
            idx   <= 8'd0;
            state <= HALT;
          end
        end
        // Reads must land on cyc==1, so an odd HALT cycle inserts one ALIGN cycle
        HALT:  state <= cyc ? ALIGN : READ;
        ALIGN: state <= READ;
        READ: begin
          latch <= bdata;
          state <= WRITE;
        end
        WRITE: begin
          if (idx == 8'hFF) begin
            state <= IDLE;
          end else begin
            idx   <= idx + 8'd1;
            state <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ea   = 16'h0000;
    din  = 8'h00;
    WREQ = 1'b0;
    RD   = 1'b0;
    RDY  = 1'b0;
    BUSY = 1'b1;
    case (state)
      IDLE: begin
        ea   = ea_cpu;
        din  = din_cpu;
        WREQ = wreq_cpu;
        RD   = rd_cpu;
        RDY  = 1'b1;
        BUSY = 1'b0;
      end
      READ: begin
        ea = {page, idx};
        RD = 1'b1;
      end
      WRITE: begin
        ea   = OAM_REG;
        din  = latch;
        WREQ = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Randomized bench for oam_dma: a queue-based bus-trace model of each transfer is
// compared cycle by cycle against the DUT outputs.
module tb_oam_dma;

  logic        CLKCPU = 1'b0;
  logic        RESET  = 1'b1;
  logic [15:0] ea_cpu = 16'h0000;
  logic [7:0]  din_cpu = 8'h00;
  logic        wreq_cpu = 1'b0;
  logic        rd_cpu = 1'b0;
  logic [7:0]  bdata;
  logic [15:0] ea;
  logic [7:0]  din;
  logic        WREQ, RD, RDY, BUSY;

  logic [7:0]  key = 8'h00;
  bit          par = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          oam_wr = 0;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
    logic        w;
    logic        r;
  } bus_t;

  oam_dma dut (
    .CLKCPU   (CLKCPU),
    .RESET    (RESET),
    .ea_cpu   (ea_cpu),
    .din_cpu  (din_cpu),
    .wreq_cpu (wreq_cpu),
    .rd_cpu   (rd_cpu),
    .bdata    (bdata),
    .ea       (ea),
    .din      (din),
    .WREQ     (WREQ),
    .RD       (RD),
    .RDY      (RDY),
    .BUSY     (BUSY)
  );

  always #5 CLKCPU = ~CLKCPU;

  // Memory model: every address returns its low byte XOR a per-test key
  assign bdata = ea[7:0] ^ key;

  // Bus-cycle parity as the spec defines it: cleared by reset, toggles every edge
  always @(posedge CLKCPU) par <= RESET ? 1'b0 : ~par;

  always @(negedge CLKCPU) if (BUSY && WREQ && ea == 16'h2004) oam_wr++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(logic [15:0] a, logic [7:0] d, logic w, logic r,
                                     logic rdy, logic busy);
    return {4'h0, a, d, w, r, rdy, busy};
  endfunction

  task automatic idle_drive();
    ea_cpu = 16'($urandom);
    if (ea_cpu == 16'h4014) ea_cpu = 16'h4015;
    din_cpu  = 8'($urandom);
    wreq_cpu = 1'($urandom_range(0, 1));
    rd_cpu   = wreq_cpu ? 1'b0 : 1'($urandom_range(0, 1));
  endtask

  task automatic check_pass(input string tag);
    @(negedge CLKCPU);
    chk(tag, pk(ea, din, WREQ, RD, RDY, BUSY), pk(ea_cpu, din_cpu, wreq_cpu, rd_cpu, 1'b1, 1'b0));
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge CLKCPU); #1;
      idle_drive();
      check_pass("pass");
    end
  endtask

  // want: 0/1 = required cyc in the HALT cycle, -1 = trigger in the very next cycle
  task automatic trigger(input logic [7:0] pg, input int want, output bit hp);
    hp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLKCPU); #1;
      if (want < 0 || par == (want == 0)) begin
        ea_cpu = 16'h4014; din_cpu = pg; wreq_cpu = 1'b1; rd_cpu = 1'b0;
        hp = ~par;
        check_pass("trig");
        return;
      end
      idle_drive();
      check_pass("pass");
    end
  endtask

  task automatic body(input logic [7:0] pg, input bit hp, input bit junk, input int abort_at);
    bus_t q[$];
    bus_t e;
    logic [7:0] dobs;
    int stall = 0;
    q.push_back({16'h0000, 8'h00, 1'b0, 1'b0});
    if (hp) q.push_back({16'h0000, 8'h00, 1'b0, 1'b0});
    for (int i = 0; i < 256; i++) begin
      q.push_back({pg, 8'(i), 8'h00, 1'b0, 1'b1});
      q.push_back({16'h2004, 8'(i) ^ key, 1'b1, 1'b0});
    end
    for (int k = 0; k < q.size(); k++) begin
      @(posedge CLKCPU); #1;
      if (junk && $urandom_range(0, 1)) begin
        ea_cpu   = $urandom_range(0, 1) ? 16'h4014 : 16'h2006;
        din_cpu  = 8'($urandom);
        wreq_cpu = 1'b1;
        rd_cpu   = 1'b0;
      end else begin
        idle_drive();
      end
      RESET = (k == abort_at);
      @(negedge CLKCPU);
      e = q[k];
      dobs = e.r ? 8'h00 : din;
      if (!RDY) stall++;
      chk("dma", pk(ea, dobs, WREQ, RD, RDY, BUSY), pk(e.a, e.d, e.w, e.r, 1'b0, 1'b1));
      if (e.r) chk("rd_cyc", 32'(par), 32'd1);
      if (k == abort_at) begin
        @(posedge CLKCPU); #1;
        RESET = 1'b0;
        idle_drive();
        wreq_cpu = 1'b0;
        rd_cpu   = 1'b0;
        check_pass("post_rst");
        return;
      end
    end
    chk("stall", 32'(stall), hp ? 32'd514 : 32'd513);
  endtask

  initial begin
    bit hp;
    int n0;
    logic [7:0] pg;
    RESET = 1'b1;
    @(posedge CLKCPU);
    @(posedge CLKCPU); #1;
    RESET = 1'b0;
    ea_cpu = 16'h2002; rd_cpu = 1'b1; wreq_cpu = 1'b0; din_cpu = 8'h00;
    check_pass("reset_pass");
    idle_cycles(5);

    key = 8'h5A;
    trigger(8'h02, 0, hp);
    chk("halt_par0", 32'(hp), 32'd0);
    body(8'h02, hp, 1'b0, -1);
    idle_cycles(3);

    trigger(8'h02, 1, hp);
    chk("halt_par1", 32'(hp), 32'd1);
    body(8'h02, hp, 1'b0, -1);
    idle_cycles(2);

    key = 8'($urandom);
    pg  = 8'($urandom);
    trigger(pg, -1, hp);
    body(pg, hp, 1'b0, 1 + int'(hp) + 200);
    trigger(8'h03, -1, hp);
    body(8'h03, hp, 1'b0, -1);
    idle_cycles(2);

    key = 8'($urandom);
    pg  = 8'($urandom);
    trigger(pg, -1, hp);
    body(pg, hp, 1'b1, -1);
    idle_cycles(2);

    key = 8'($urandom);
    pg  = 8'($urandom);
    n0  = oam_wr;
    trigger(pg, -1, hp);
    body(pg, hp, 1'b0, -1);
    trigger(8'h07, -1, hp);
    body(8'h07, hp, 1'b0, -1);
    idle_cycles(2);
    chk("oam_wr", 32'(oam_wr - n0), 32'd512);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
